// File: rtl/controle_chamadas_if.sv
// Bundle of signals between the movement FSM / button I/O side and the
// call-control block. The FSM side is the master: it supplies the stage
// and buttons, and receives floor, pending calls and the dwell pulse.
interface controle_chamadas_if;
  logic [5:0] Stage;
  logic [3:0] btn;
  logic [1:0] FF;
  logic [3:0] G;
  logic       count;

  modport master (output Stage, output btn, input FF, input G, input count);
  modport slave  (input Stage, input btn, output FF, output G, output count);
endinterface

// File: rtl/controle_chamadas.sv
// Call control companion for the elevator movement FSM: latches calls,
// clears the call being served on door entry, tracks the floor by timing
// continuous travel, and times the door dwell.
module controle_chamadas #(
  parameter int TRAVEL = 8,  // cycles of continuous UP/DOWN per floor step (>= 2)
  parameter int DWELL  = 4   // cycles in a door stage before count pulses (>= 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  controle_chamadas_if.slave   bus
);

  localparam int TW = (TRAVEL > 1) ? $clog2(TRAVEL) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DWELL - 1);

  typedef enum logic [2:0] {
    ST_STOP = 3'd0,
    ST_UP   = 3'd1,
    ST_CCU  = 3'd2,
    ST_DMU  = 3'd3,
    ST_DOWN = 3'd4,
    ST_DMD  = 3'd5,
    ST_CCD  = 3'd6
  } stage_t;

  stage_t        stage;
  stage_t        pstage;
  logic [1:0]    ff;
  logic [3:0]    g;
  logic          count_q;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] dcnt;

  logic          is_door;
  logic          door_entry;
  logic          reversal;
  logic [3:0]    clr;

  // Decode the raw stage code; anything outside the defined set acts as STOP.
  always_comb begin
    stage = ST_STOP;
    if (bus.Stage < 6'd7)
      stage = stage_t'(bus.Stage[2:0]);
  end

  // Door entry, direct reversal and the one-hot clear of the served floor.
  always_comb begin
    is_door    = (stage == ST_CCU) || (stage == ST_CCD);
    door_entry = is_door && (stage != pstage);
    reversal   = ((stage == ST_UP)   && (pstage == ST_DOWN)) ||
                 ((stage == ST_DOWN) && (pstage == ST_UP));
    clr        = door_entry ? (4'b0001 << ff) : 4'b0000;
  end

  // Previous stage and the pending-call register; clear beats a press.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values, and the reset branch sits in the sensitivity list so it
  // acts without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstage <= ST_STOP;
      g      <= 4'b0000;
    end else begin
      pstage <= stage;
      g      <= (g | bus.btn) & ~clr;
    end
  end

  // Floor tracking: count travel cycles and step the floor, saturating at 0/3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
      ff   <= 2'd0;
    end else if ((stage == ST_UP) || (stage == ST_DOWN)) begin
      if (reversal) begin
        tcnt <= '0;
      end else if (tcnt == T_LAST) begin
        tcnt <= '0;
        if ((stage == ST_UP) && (ff != 2'd3))
          ff <= ff + 2'd1;
        else if ((stage == ST_DOWN) && (ff != 2'd0))
          ff <= ff - 2'd1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end else begin
      tcnt <= '0;
    end
  end

  // Door dwell timer: pulse count every DWELL cycles spent in a door stage;
  // a fresh entry (including CCU<->CCD) restarts the count from the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt    <= '0;
      count_q <= 1'b0;
    end else if (is_door) begin
      if (door_entry) begin
        dcnt    <= DW'(1);
        count_q <= 1'b0;
      end else if (dcnt == D_LAST) begin
        dcnt    <= '0;
        count_q <= 1'b1;
      end else begin
        dcnt    <= dcnt + 1'b1;
        count_q <= 1'b0;
      end
    end else begin
      dcnt    <= '0;
      count_q <= 1'b0;
    end
  end

  assign bus.FF    = ff;
  assign bus.G     = g;
  assign bus.count = count_q;

endmodule

// File: tb/tb_controle_chamadas.sv
// Scoreboard bench for controle_chamadas (TRAVEL=8, DWELL=4). Stimulus pushes
// the hand-computed outputs expected after each edge; a monitor compares them.
module tb_controle_chamadas;

  localparam logic [5:0] S_STOP = 6'd0, S_UP = 6'd1, S_CCU = 6'd2,
                         S_DOWN = 6'd4, S_CCD = 6'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int         due;
    logic [1:0] ff;
    logic [3:0] g;
    logic       cnt;
    string      name;
  } exp_t;

  exp_t sb[$];

  controle_chamadas_if bus ();

  controle_chamadas #(.TRAVEL(8), .DWELL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".FF"},    {6'd0, bus.FF},    {6'd0, e.ff});
      check({e.name, ".G"},     {4'd0, bus.G},     {4'd0, e.g});
      check({e.name, ".count"}, {7'd0, bus.count}, {7'd0, e.cnt});
    end
  end

  // Apply one cycle of inputs and push what must be visible after the edge.
  task automatic drive(input logic [5:0] st, input logic [3:0] b,
                       input logic [1:0] ff, input logic [3:0] g,
                       input logic cnt, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    bus.Stage = st;
    bus.btn   = b;
    e.due  = cyc + 1;
    e.ff   = ff;
    e.g    = g;
    e.cnt  = cnt;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never compared", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [3:0] g_exp;
    bit done;
    bus.Stage = S_STOP;
    bus.btn   = 4'b0000;
    #2;
    check("reset_ff",    {6'd0, bus.FF},    8'd0);
    check("reset_g",     {4'd0, bus.G},     8'd0);
    check("reset_count", {7'd0, bus.count}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Latch a call, then door entry on another floor keeps it.
    drive(S_STOP, 4'b0100, 2'd0, 4'b0100, 1'b0, "latch");
    drive(S_STOP, 4'b0000, 2'd0, 4'b0100, 1'b0, "hold");
    drive(S_CCU,  4'b0100, 2'd0, 4'b0100, 1'b0, "ccu_f0_keep");
    for (int j = 1; j < 4; j++)
      drive(S_CCU, 4'b0000, 2'd0, 4'b0100, (j == 3), "dwell_ccu");
    drive(S_STOP, 4'b0000, 2'd0, 4'b0100, 1'b0, "dwell_end");

    // Travel up to the top and saturate.
    for (int j = 0; j < 32; j++)
      drive(S_UP, 4'b0000, (j >= 23) ? 2'd3 : 2'((j + 1) / 8), 4'b0100, 1'b0, "up_run");
    drive(S_STOP, 4'b0000, 2'd3, 4'b0100, 1'b0, "up_stop");
    // Travel down to the bottom and saturate.
    for (int j = 0; j < 32; j++)
      drive(S_DOWN, 4'b0000, (j >= 23) ? 2'd0 : 2'(3 - (j + 1) / 8), 4'b0100, 1'b0, "down_run");
    drive(S_STOP, 4'b0000, 2'd0, 4'b0100, 1'b0, "down_stop");

    // Travel abort: a STOP in the middle restarts the floor timer.
    for (int j = 0; j < 5; j++)
      drive(S_UP, 4'b0000, 2'd0, 4'b0100, 1'b0, "abort_up1");
    drive(S_STOP, 4'b0000, 2'd0, 4'b0100, 1'b0, "abort_stop");
    for (int j = 0; j < 8; j++)
      drive(S_UP, 4'b0000, (j == 7) ? 2'd1 : 2'd0, 4'b0100, 1'b0, "abort_up2");
    drive(S_STOP, 4'b0000, 2'd1, 4'b0100, 1'b0, "f1_stop");
    for (int j = 0; j < 8; j++)
      drive(S_UP, 4'b0000, (j == 7) ? 2'd2 : 2'd1, 4'b0100, 1'b0, "up_to_f2");
    drive(S_STOP, 4'b0000, 2'd2, 4'b0100, 1'b0, "f2_stop");

    // Clear beats a held press on the served floor; re-latched next edge.
    drive(S_CCU,  4'b0100, 2'd2, 4'b0000, 1'b0, "clear_wins");
    drive(S_STOP, 4'b0100, 2'd2, 4'b0100, 1'b0, "relatch");
    drive(S_STOP, 4'b0000, 2'd2, 4'b0100, 1'b0, "relatch_hold");

    // Door dwell on CCD with re-pulses; a press mid-dwell is latched.
    for (int j = 0; j < 13; j++) begin
      g_exp = (j >= 5) ? 4'b0100 : 4'b0000;
      drive(S_CCD, (j == 5) ? 4'b0100 : 4'b0000, 2'd2, g_exp, (j % 4 == 3), "dwell_ccd");
    end
    // Direct CCD->CCU is a new entry: clear and restart the dwell.
    for (int j = 0; j < 4; j++)
      drive(S_CCU, 4'b0000, 2'd2, 4'b0000, (j == 3), "ccd_to_ccu");
    // Leaving the door early gives no pulse.
    for (int j = 0; j < 2; j++)
      drive(S_CCD, 4'b0000, 2'd2, 4'b0000, 1'b0, "door_abort");
    for (int j = 0; j < 4; j++)
      drive(S_STOP, 4'b0000, 2'd2, 4'b0000, 1'b0, "door_abort_idle");

    // Invalid stage codes act as STOP and still latch buttons.
    drive(6'd63, 4'b0001, 2'd2, 4'b0001, 1'b0, "invalid63");
    for (int j = 0; j < 9; j++)
      drive(6'd7, 4'b0000, 2'd2, 4'b0001, 1'b0, "invalid7");

    // Asynchronous reset mid-travel.
    drive(S_STOP, 4'b1010, 2'd2, 4'b1011, 1'b0, "pre_reset");
    for (int j = 0; j < 3; j++)
      drive(S_UP, 4'b0000, 2'd2, 4'b1011, 1'b0, "pre_reset_up");
    drain();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_ff",    {6'd0, bus.FF},    8'd0);
    check("async_rst_g",     {4'd0, bus.G},     8'd0);
    check("async_rst_count", {7'd0, bus.count}, 8'd0);
    bus.Stage = S_STOP;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 8; j++)
      drive(S_UP, 4'b0000, (j == 7) ? 2'd1 : 2'd0, 4'b0000, 1'b0, "post_rst_up");
    drive(S_STOP, 4'b0000, 2'd1, 4'b0000, 1'b0, "post_rst_stop");
    for (int j = 0; j < 8; j++)
      drive(S_DOWN, 4'b0000, (j == 7) ? 2'd0 : 2'd1, 4'b0000, 1'b0, "post_rst_down");
    drive(S_STOP, 4'b0000, 2'd0, 4'b0000, 1'b0, "loop_start");
    drain();

    // Closed loop with a minimal movement FSM: call floor 3 from floor 0.
    @(posedge clk);
    #1;
    bus.btn = 4'b1000;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk);
      #1;
      bus.btn = 4'b0000;
      case (bus.Stage)
        S_STOP: if (bus.G == 4'b0000 && k > 0) done = 1'b1;
                else if (bus.G[bus.FF]) bus.Stage = S_CCU;
                else if ((bus.G >> bus.FF) != 4'b0000) bus.Stage = S_UP;
        S_UP:   if (bus.G[bus.FF]) bus.Stage = S_CCU;
        S_CCU:  if (bus.count) bus.Stage = S_STOP;
        default: bus.Stage = S_STOP;
      endcase
    end
    check("loop_done",  {7'd0, done},         8'd1);
    check("loop_ff",    {6'd0, bus.FF},       8'd3);
    check("loop_g",     {4'd0, bus.G},        8'd0);
    check("loop_stage", {2'd0, bus.Stage},    {2'd0, S_STOP});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
